// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/forwarding control with DMem wait FSM and stall-cycle counter
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_WantRs,
  input  logic             ID_NeedRs,
  input  logic             ID_WantRt,
  input  logic             ID_NeedRt,
  input  logic [4:0]       EX_Rs,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_WantRsByEX,
  input  logic             EX_NeedRsByEX,
  input  logic             EX_WantRtByEX,
  input  logic             EX_NeedRtByEX,
  input  logic [4:0]       EX_RtRd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       MEM_RtRd,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic [4:0]       WB_RtRd,
  input  logic             WB_RegWrite,
  input  logic             IF_Busy,
  input  logic             DMem_Ack,
  input  logic             Exc_Flush,
  input  logic             CntClr,
  output logic             IF_Stall,
  output logic             ID_Stall,
  output logic             EX_Stall,
  output logic             MEM_Stall,
  output logic             WB_Stall,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             EX_Flush,
  output logic             MEM_Flush,
  output logic [1:0]       ID_RsFwd,
  output logic [1:0]       ID_RtFwd,
  output logic [1:0]       EX_RsFwd,
  output logic [1:0]       EX_RtFwd,
  output logic             Bus_Error,
  output logic [CNT_W-1:0] StallCycles
);
  localparam int WW = ($clog2(MEM_TIMEOUT) > 5) ? $clog2(MEM_TIMEOUT) : 5;
  typedef enum logic [1:0] {M_IDLE, M_WAIT, M_ERR} mstate_t;
  mstate_t state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic req, mem_wait, err, ok, hz_id, hz_ex, mem_src, pend_flush, flush, unused;
  function automatic logic match(input logic [4:0] r, input logic [4:0] d, input logic we);
    return we && (d == r) && (r != 5'd0);
  endfunction
  function automatic logic [1:0] fwd(input logic [4:0] r, input logic [4:0] md, input logic mwe,
                                     input logic [4:0] wd, input logic wwe);
    return match(r, md, mwe) ? 2'b01 : match(r, wd, wwe) ? 2'b10 : 2'b00;
  endfunction
  assign unused   = ^{EX_WantRsByEX, EX_WantRtByEX};
  assign req      = MEM_MemRead | MEM_MemWrite;
  assign err      = state == M_ERR;
  assign ok       = ~rst & ~err;
  assign mem_wait = ~DMem_Ack & ((state == M_IDLE && req) || state == M_WAIT);
  assign mem_src  = MEM_RegWrite & ~MEM_MemRead;
  assign hz_id = (ID_NeedRs & match(ID_Rs, EX_RtRd, EX_RegWrite))
               | (ID_NeedRs & match(ID_Rs, MEM_RtRd, MEM_MemRead))
               | (ID_WantRs & match(ID_Rs, EX_RtRd, EX_MemRead))
               | (ID_NeedRt & match(ID_Rt, EX_RtRd, EX_RegWrite))
               | (ID_NeedRt & match(ID_Rt, MEM_RtRd, MEM_MemRead))
               | (ID_WantRt & match(ID_Rt, EX_RtRd, EX_MemRead));
  assign hz_ex = (EX_NeedRsByEX & match(EX_Rs, MEM_RtRd, MEM_MemRead))
               | (EX_NeedRtByEX & match(EX_Rt, MEM_RtRd, MEM_MemRead));
  assign MEM_Stall = ok & mem_wait;
  assign EX_Stall  = MEM_Stall | (ok & hz_ex);
  assign ID_Stall  = EX_Stall | (ok & hz_id);
  assign IF_Stall  = ID_Stall | (ok & IF_Busy);
  assign WB_Stall  = 1'b0;
  // a deferred exception flush waits until the memory stage is released
  assign flush     = ~rst & (err | (~MEM_Stall & (Exc_Flush | pend_flush)));
  assign IF_Flush  = flush;
  assign ID_Flush  = flush;
  assign EX_Flush  = flush;
  assign MEM_Flush = flush;
  assign Bus_Error = ~rst & err;
  assign ID_RsFwd  = rst ? 2'b00 : fwd(ID_Rs, MEM_RtRd, mem_src, WB_RtRd, WB_RegWrite);
  assign ID_RtFwd  = rst ? 2'b00 : fwd(ID_Rt, MEM_RtRd, mem_src, WB_RtRd, WB_RegWrite);
  assign EX_RsFwd  = rst ? 2'b00 : fwd(EX_Rs, MEM_RtRd, mem_src, WB_RtRd, WB_RegWrite);
  assign EX_RtFwd  = rst ? 2'b00 : fwd(EX_Rt, MEM_RtRd, mem_src, WB_RtRd, WB_RegWrite);
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    case (state)
      M_IDLE: if (req && !DMem_Ack) begin
        state_n = M_WAIT;
        wcnt_n  = WW'(1);
      end
      M_WAIT: if (DMem_Ack) state_n = M_IDLE;
        else if (wcnt == WW'(MEM_TIMEOUT - 1)) state_n = M_ERR;
        else wcnt_n = wcnt + 1'b1;
      default: state_n = M_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= M_IDLE;
      wcnt        <= '0;
      pend_flush  <= 1'b0;
      StallCycles <= '0;
    end else begin
      state       <= state_n;
      wcnt        <= wcnt_n;
      pend_flush  <= MEM_Stall & (Exc_Flush | pend_flush);
      StallCycles <= CntClr ? '0
                   : ((IF_Stall | ID_Stall | EX_Stall | MEM_Stall) && !(&StallCycles)) ? StallCycles + 1'b1
                   : StallCycles;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 5;
  localparam logic [4:0] S0 = 5'b00000, SA = 5'b11110;
  localparam logic [3:0] F0 = 4'h0, FA = 4'hF;
  localparam logic [7:0] W0 = 8'h00;
  logic clk = 1'b0, rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_RtRd, MEM_RtRd, WB_RtRd;
  logic ID_WantRs, ID_NeedRs, ID_WantRt, ID_NeedRt;
  logic EX_WantRsByEX, EX_NeedRsByEX, EX_WantRtByEX, EX_NeedRtByEX, EX_RegWrite, EX_MemRead;
  logic MEM_RegWrite, MEM_MemRead, MEM_MemWrite, WB_RegWrite, IF_Busy, DMem_Ack, Exc_Flush, CntClr;
  logic IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall, IF_Flush, ID_Flush, EX_Flush, MEM_Flush;
  logic [1:0] ID_RsFwd, ID_RtFwd, EX_RsFwd, EX_RtFwd;
  logic Bus_Error;
  logic [CNT_W-1:0] StallCycles;
  typedef struct {
    string name;
    logic [4:0] st;
    logic [3:0] fl;
    logic [7:0] fw;
    logic be;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [17:0] act, want;
  int checks = 0, errors = 0;
  logic [CNT_W-1:0] mc = '0;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_WantRs(ID_WantRs), .ID_NeedRs(ID_NeedRs),
    .ID_WantRt(ID_WantRt), .ID_NeedRt(ID_NeedRt),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WantRsByEX(EX_WantRsByEX), .EX_NeedRsByEX(EX_NeedRsByEX),
    .EX_WantRtByEX(EX_WantRtByEX), .EX_NeedRtByEX(EX_NeedRtByEX),
    .EX_RtRd(EX_RtRd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .MEM_RtRd(MEM_RtRd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .WB_RtRd(WB_RtRd), .WB_RegWrite(WB_RegWrite),
    .IF_Busy(IF_Busy), .DMem_Ack(DMem_Ack), .Exc_Flush(Exc_Flush), .CntClr(CntClr),
    .IF_Stall(IF_Stall), .ID_Stall(ID_Stall), .EX_Stall(EX_Stall), .MEM_Stall(MEM_Stall), .WB_Stall(WB_Stall),
    .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .EX_Flush(EX_Flush), .MEM_Flush(MEM_Flush),
    .ID_RsFwd(ID_RsFwd), .ID_RtFwd(ID_RtFwd), .EX_RsFwd(EX_RsFwd), .EX_RtFwd(EX_RtFwd),
    .Bus_Error(Bus_Error), .StallCycles(StallCycles)
  );
  always #5 clk = ~clk;
  task automatic clr_in();
    {ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_RtRd, MEM_RtRd, WB_RtRd} = '0;
    {ID_WantRs, ID_NeedRs, ID_WantRt, ID_NeedRt} = '0;
    {EX_WantRsByEX, EX_NeedRsByEX, EX_WantRtByEX, EX_NeedRtByEX, EX_RegWrite, EX_MemRead} = '0;
    {MEM_RegWrite, MEM_MemRead, MEM_MemWrite, WB_RegWrite, IF_Busy, DMem_Ack, Exc_Flush, CntClr} = '0;
  endtask
  // st = {IF,ID,EX,MEM,WB}, fl = {IF,ID,EX,MEM}, fw = {ID_Rs,ID_Rt,EX_Rs,EX_Rt}
  task automatic apply(input string n, input logic [4:0] st, input logic [3:0] fl,
                       input logic [7:0] fw, input logic be);
    exp_t e;
    e.name = n; e.st = st; e.fl = fl; e.fw = fw; e.be = be; e.cnt = mc;
    q.push_back(e);
    if (rst || CntClr) mc = '0;
    else if (|st[4:1] && mc != {CNT_W{1'b1}}) mc = mc + 1'b1;
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      act = {IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall, IF_Flush, ID_Flush, EX_Flush, MEM_Flush,
             ID_RsFwd, ID_RtFwd, EX_RsFwd, EX_RtFwd, Bus_Error};
      want = {me.st, me.fl, me.fw, me.be};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL %s ctl got=%b want=%b", me.name, act, want);
      end
      checks++;
      if (StallCycles !== me.cnt) begin
        errors++;
        $display("FAIL %s StallCycles got=%0d want=%0d", me.name, StallCycles, me.cnt);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    clr_in();
    rst = 1'b1;
    @(posedge clk); #1;
    IF_Busy = 1; MEM_MemRead = 1; Exc_Flush = 1; WB_RegWrite = 1; WB_RtRd = 4; EX_Rs = 4;
    apply("rst0", S0, F0, W0, 0);
    apply("rst1", S0, F0, W0, 0);
    rst = 1'b0; clr_in();
    apply("idle", S0, F0, W0, 0);
    EX_RegWrite = 1; EX_RtRd = 5; ID_Rs = 5; ID_NeedRs = 1;
    apply("br_ex", 5'b11000, F0, W0, 0);
    ID_Rs = 0; EX_RtRd = 0;
    apply("r0_nostall", S0, F0, W0, 0);
    clr_in();
    MEM_RegWrite = 1; MEM_RtRd = 3; WB_RegWrite = 1; WB_RtRd = 3; EX_Rs = 3;
    apply("fwd_mem", S0, F0, 8'b00_00_01_00, 0);
    MEM_RegWrite = 0;
    apply("fwd_wb", S0, F0, 8'b00_00_10_00, 0);
    EX_Rs = 0;
    apply("fwd_r0", S0, F0, W0, 0);
    MEM_RegWrite = 1; ID_Rt = 3; EX_Rt = 3;
    apply("fwd_rt", S0, F0, 8'b00_01_00_01, 0);
    MEM_MemRead = 1; DMem_Ack = 1;
    apply("fwd_load_wb", S0, F0, 8'b00_10_00_10, 0);
    clr_in();
    EX_MemRead = 1; EX_RegWrite = 1; EX_RtRd = 7; ID_Rt = 7; ID_WantRt = 1;
    apply("ldu", 5'b11000, F0, W0, 0);
    EX_MemRead = 0; EX_RegWrite = 0; EX_RtRd = 0;
    MEM_MemRead = 1; MEM_RegWrite = 1; MEM_RtRd = 7; DMem_Ack = 1;
    apply("ldu_adv", S0, F0, W0, 0);
    ID_Rt = 0; ID_WantRt = 0; EX_Rt = 7; EX_NeedRtByEX = 1;
    apply("hz_ex", 5'b11100, F0, W0, 0);
    EX_Rt = 0; EX_NeedRtByEX = 0; ID_Rs = 7; ID_NeedRs = 1;
    apply("hz_id_mem", 5'b11000, F0, W0, 0);
    clr_in();
    MEM_MemRead = 1; MEM_RtRd = 2;
    repeat (3) apply("dwait", SA, F0, W0, 0);
    DMem_Ack = 1;
    apply("dack", S0, F0, W0, 0);
    clr_in();
    apply("after_ack", S0, F0, W0, 0);
    Exc_Flush = 1;
    apply("exc", S0, FA, W0, 0);
    Exc_Flush = 0;
    apply("exc_once", S0, F0, W0, 0);
    MEM_MemWrite = 1; Exc_Flush = 1;
    apply("exc_wait0", SA, F0, W0, 0);
    Exc_Flush = 0;
    apply("exc_wait1", SA, F0, W0, 0);
    DMem_Ack = 1;
    apply("exc_issue", S0, FA, W0, 0);
    clr_in();
    apply("exc_done", S0, F0, W0, 0);
    MEM_MemRead = 1;
    repeat (16) apply("to_wait", SA, F0, W0, 0);
    IF_Busy = 1; Exc_Flush = 1;
    apply("bus_err", S0, FA, W0, 1);
    clr_in();
    apply("err_idle", S0, F0, W0, 0);
    MEM_MemRead = 1;
    apply("rw0", SA, F0, W0, 0);
    apply("rw1", SA, F0, W0, 0);
    rst = 1'b1;
    apply("rw_rst", S0, F0, W0, 0);
    rst = 1'b0;
    apply("rw_idle", SA, F0, W0, 0);
    repeat (14) apply("rw_wait", SA, F0, W0, 0);
    DMem_Ack = 1;
    apply("rw_ack", S0, F0, W0, 0);
    clr_in();
    IF_Busy = 1;
    repeat (35) apply("busy_sat", 5'b10000, F0, W0, 0);
    CntClr = 1;
    apply("cnt_clr", 5'b10000, F0, W0, 0);
    CntClr = 0; IF_Busy = 0;
    apply("cleared", S0, F0, W0, 0);
    apply("cleared2", S0, F0, W0, 0);
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
